coin_acceptor: RTL and testbench

Front-end stage that feeds the newspaper vending FSM. It turns two raw, bouncy coin-slot sensors (5-dollar and 10-dollar) into clean single-cycle coin codes on the 2-bit coin bus the vending FSM consumes (2'b01 = 5, 2'b10 = 10, 2'b00 = none). It also rejects ambiguous insertions, flags jammed sensors, and refuses coins while the vending FSM is dispensing.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/coin_acceptor_sync2.sv | 39 +++
 rtl/coin_acceptor.sv | 200 ++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the coin acceptor and the newspaper vending FSM:
//   - coin codes carried on the 2-bit coin bus
//   - the acceptor FSM state enum
//   - dollar value constants for each coin kind
// No ports (package).
// ---------------------------------------------------------------------------
package vend_pkg;

  // Coin bus codes; 2'b11 is never driven.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  // Dollar value of each coin kind.
  localparam logic [15:0] VALUE_5  = 16'd5;
  localparam logic [15:0] VALUE_10 = 16'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_EMIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_JAM     = 3'd4
  } acc_state_e;

  // Maps a coin code to its dollar value; unused codes are worth nothing.
  function automatic logic [15:0] coin_value(input logic [1:0] code);
    logic [15:0] value;
    case (code)
      COIN_5:  value = VALUE_5;
      COIN_10: value = VALUE_10;
      default: value = 16'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for one asynchronous sensor input.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high reset (clears both flops)
//   d      in   asynchronous input
//   q      out  synchronized output, two cycles of latency
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Turns two bouncy coin-slot sensors into clean one-cycle coin codes for the
// vending FSM, rejects ambiguous insertions, flags jammed sensors and
// refuses coins while the vending FSM is dispensing.
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-high reset
//   nickel_sense  in   raw 5-dollar sensor (asynchronous)
//   dime_sense    in   raw 10-dollar sensor (asynchronous)
//   inhibit       in   high while the vending FSM dispenses
//   coin          out  coin code, one-cycle pulse (vend_pkg codes)
//   reject        out  one-cycle pulse, coin returned to user
//   jam           out  level, sensor stuck high
//   coin_total    out  running dollar sum, saturating (COIN_ACCEPTOR_TOTAL_EN only)
//   busy          out  high whenever the FSM is not idle
// Optional feature macro: COIN_ACCEPTOR_TOTAL_EN.
// ---------------------------------------------------------------------------
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nickel_sense,
  input  logic        dime_sense,
  input  logic        inhibit,
  output logic [1:0]  coin,
  output logic        reject,
  output logic        jam,
`ifdef COIN_ACCEPTOR_TOTAL_EN
  output logic [15:0] coin_total,
`endif
  output logic        busy
);

  localparam logic [7:0] DEB_LIMIT = DEBOUNCE_CYCLES[7:0];
  localparam logic [7:0] JAM_LIMIT = JAM_CYCLES[7:0];

  logic sn, sd;

  sync2 u_sync_nickel (.clock(clock), .reset(reset), .d(nickel_sense), .q(sn));
  sync2 u_sync_dime   (.clock(clock), .reset(reset), .d(dime_sense),   .q(sd));

  acc_state_e state_d, state_q;
  logic [7:0] cnt_d, cnt_q;
  logic [7:0] jcnt_d, jcnt_q;
  logic [1:0] kind_d, kind_q;
  logic [1:0] coin_d, coin_q;
  logic       reject_d, reject_q;
  logic       jam_d, jam_q;
  logic       busy_d, busy_q;
  logic       latched_s, other_s;

  // Acceptor FSM next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jcnt_d   = jcnt_q;
    kind_d   = kind_q;
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    jam_d    = 1'b0;
    // Sensor being qualified versus the one that must stay quiet.
    latched_s = (kind_q == COIN_5) ? sn : sd;
    other_s   = (kind_q == COIN_5) ? sd : sn;
    case (state_q)
      ST_IDLE: begin
        if (sn && sd) begin
          reject_d = 1'b1;
          jcnt_d   = 8'd0;
          state_d  = ST_RELEASE;
        end else if (sn) begin
          kind_d  = COIN_5;
          cnt_d   = 8'd1;
          state_d = ST_QUAL;
        end else if (sd) begin
          kind_d  = COIN_10;
          cnt_d   = 8'd1;
          state_d = ST_QUAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUAL: begin
        if (!latched_s) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else if (other_s) begin
          reject_d = 1'b1;
          cnt_d    = 8'd0;
          jcnt_d   = 8'd0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Outputs are registered, so the coin/reject is decided on the
          // edge that enters EMIT and is visible for the whole EMIT cycle.
          if (cnt_d == DEB_LIMIT) begin
            state_d = ST_EMIT;
            if (inhibit) begin
              reject_d = 1'b1;
            end else begin
              coin_d = kind_q;
            end
          end else begin
            state_d = ST_QUAL;
          end
        end
      end
      ST_EMIT: begin
        cnt_d   = 8'd0;
        jcnt_d  = 8'd0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!sn && !sd) begin
          state_d = ST_IDLE;
        end else begin
          jcnt_d = jcnt_q + 8'd1;
          if (jcnt_d == JAM_LIMIT) begin
            jam_d   = 1'b1;
            state_d = ST_JAM;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_JAM: begin
        if (!sn && !sd) begin
          jcnt_d  = 8'd0;
          state_d = ST_IDLE;
        end else begin
          jam_d   = 1'b1;
          state_d = ST_JAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      jcnt_q   <= 8'd0;
      kind_q   <= COIN_NONE;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      jcnt_q   <= jcnt_d;
      kind_q   <= kind_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      jam_q    <= jam_d;
      busy_q   <= busy_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;
  assign jam    = jam_q;
  assign busy   = busy_q;

`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [15:0] total_d, total_q;
  logic [16:0] sum_s;

  // Running total, saturating instead of wrapping.
  always_comb begin
    sum_s = {1'b0, total_q} + {1'b0, coin_value(coin_d)};
    if (sum_s[16]) begin
      total_d = 16'hFFFF;
    end else begin
      total_d = sum_s[15:0];
    end
  end

  // Running total register.
  always_ff @(posedge clock) begin
    if (reset) begin
      total_q <= 16'd0;
    end else begin
      total_q <= total_d;
    end
  end

  assign coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// ---------------------------------------------------------------------------
// tb_coin_acceptor
// Directed bench for coin_acceptor with hand-computed expectations.
// Offsets: off 0 is the first clock edge at which a newly raised raw sensor
// is sampled; outputs are observed 1 ns after each edge.
// ---------------------------------------------------------------------------
module tb_coin_acceptor;

  logic        clock;
  logic        reset;
  logic        nickel_sense;
  logic        dime_sense;
  logic        inhibit;
  logic [1:0]  coin;
  logic        reject;
  logic        jam;
  logic        busy;
`ifdef COIN_ACCEPTOR_TOTAL_EN
  logic [15:0] coin_total;
`endif

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .nickel_sense (nickel_sense),
    .dime_sense   (dime_sense),
    .inhibit      (inhibit),
    .coin         (coin),
    .reject       (reject),
    .jam          (jam),
`ifdef COIN_ACCEPTOR_TOTAL_EN
    .coin_total   (coin_total),
`endif
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Per-scenario observations.
  int off;
  int n5, n10, nrej, nbad;
  int last5, last10, lastrej;
  int jam_rise, jam_fall;
  int busy_at [0:127];

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    off = -1;
    n5 = 0; n10 = 0; nrej = 0; nbad = 0;
    last5 = -1; last10 = -1; lastrej = -1;
    jam_rise = -1; jam_fall = -1;
    for (int i = 0; i < 128; i++) busy_at[i] = -1;
  endtask

  // One clock edge, then record what the DUT shows for the following cycle.
  task automatic step();
    @(posedge clock);
    #1;
    off++;
    if (coin == 2'b01) begin n5++; last5 = off; end
    if (coin == 2'b10) begin n10++; last10 = off; end
    if (reject) begin nrej++; lastrej = off; end
    if (coin == 2'b11 || (coin != 2'b00 && reject)) nbad++;
    if (jam && jam_rise < 0) jam_rise = off;
    if (!jam && jam_rise >= 0 && jam_fall < 0) jam_fall = off;
    if (off >= 0 && off < 128) busy_at[off] = int'(busy);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Insert one coin: sensor high for hi edges, then low for lo edges.
  task automatic insert(input bit dime, input int hi, input int lo);
    clear_stats();
    if (dime) dime_sense = 1'b1; else nickel_sense = 1'b1;
    steps(hi);
    dime_sense = 1'b0;
    nickel_sense = 1'b0;
    steps(lo);
  endtask

  initial begin
    reset = 1'b1;
    nickel_sense = 1'b0;
    dime_sense = 1'b0;
    inhibit = 1'b0;
    clear_stats();
    steps(3);
    check_eq("rst_coin", int'(coin), 0);
    check_eq("rst_reject", int'(reject), 0);
    check_eq("rst_jam", int'(jam), 0);
    check_eq("rst_busy", int'(busy), 0);
    reset = 1'b0;
    steps(2);

    // Clean nickel, 10 cycles high.
    insert(1'b0, 10, 6);
    check_eq("nickel_count", n5, 1);
    check_eq("nickel_offset", last5, 5);
    check_eq("nickel_no_dime", n10, 0);
    check_eq("nickel_no_reject", nrej, 0);
    check_eq("nickel_busy_held", busy_at[11], 1);
    check_eq("nickel_busy_drop", busy_at[12], 0);

    // Bouncing dime: 2 high, 1 low, 8 high.
    clear_stats();
    dime_sense = 1'b1;
    steps(2);
    dime_sense = 1'b0;
    step();
    dime_sense = 1'b1;
    steps(8);
    dime_sense = 1'b0;
    steps(6);
    check_eq("bounce_count", n10, 1);
    check_eq("bounce_offset", last10, 8);
    check_eq("bounce_no_reject", nrej, 0);

    // Both sensors together.
    clear_stats();
    nickel_sense = 1'b1;
    dime_sense = 1'b1;
    steps(5);
    nickel_sense = 1'b0;
    dime_sense = 1'b0;
    steps(5);
    check_eq("both_reject_count", nrej, 1);
    check_eq("both_reject_offset", lastrej, 2);
    check_eq("both_no_coin", n5 + n10, 0);
    check_eq("both_busy_release", busy_at[6], 1);
    check_eq("both_busy_idle", busy_at[7], 0);

    // Dime while dispensing, then again with inhibit released.
    inhibit = 1'b1;
    insert(1'b1, 6, 8);
    check_eq("inhibit_reject_count", nrej, 1);
    check_eq("inhibit_reject_offset", lastrej, 5);
    check_eq("inhibit_no_coin", n10, 0);
    inhibit = 1'b0;
    insert(1'b1, 6, 8);
    check_eq("free_dime_count", n10, 1);
    check_eq("free_dime_offset", last10, 5);
    check_eq("free_no_reject", nrej, 0);

    // Nickel stuck high for 100 cycles.
    insert(1'b0, 100, 6);
    check_eq("jam_coin_count", n5, 1);
    check_eq("jam_rise", jam_rise, 70);
    check_eq("jam_fall", jam_fall, 102);

    // Reset in the middle of qualification (cnt=2 after edge 3).
    clear_stats();
    nickel_sense = 1'b1;
    steps(4);
    reset = 1'b1;
    nickel_sense = 1'b0;
    step();
    check_eq("midrst_coin", int'(coin), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_reject", int'(reject), 0);
    reset = 1'b0;
    steps(8);
    check_eq("midrst_no_coin", n5 + n10, 0);

`ifdef COIN_ACCEPTOR_TOTAL_EN
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(2);
    check_eq("total_after_reset", int'(coin_total), 0);
    insert(1'b1, 6, 8);
    insert(1'b1, 6, 8);
    insert(1'b1, 6, 8);
    insert(1'b0, 6, 8);
    check_eq("total_35", int'(coin_total), 35);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("total_cleared", int'(coin_total), 0);
`endif

    check_eq("coin_reject_exclusive", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
